// File: rtl/fetch_mem_arbiter.sv
// ----------------------------------------------------------------------------
// fetch_mem_arbiter: round-robin sharing of one memory port between icache
// block refills and dcache block refills/writebacks.       Revision 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fetch_mem_arbiter #(
  parameter int BLOCK_WORDS = 2,
  parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic [31:0]      i_load_word,
  output logic             i_load_valid,
  output logic             i_done,
  input  logic             d_req,
  input  logic             d_write,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_store_word,
  output logic [31:0]      d_load_word,
  output logic             d_load_valid,
  output logic             d_done,
  output logic [IDX_W-1:0] word_idx,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_store,
  input  logic [31:0]      mem_load,
  input  logic             mem_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_XFER = 2'd1;
  localparam logic [1:0] D_XFER = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             last_grant;
  logic             grant_nxt;
  logic             granted_req;
  logic             beat;
  logic             last_beat;
  logic             unused_addr_bits;

  // Block base low bits are replaced by the word index, so they never matter.
  assign unused_addr_bits = ^{i_addr[IDX_W+1:0], d_addr[IDX_W+1:0]};

  assign granted_req = (state == I_XFER) ? i_req :
                       (state == D_XFER) ? d_req : 1'b0;
  assign beat        = granted_req & mem_ready;
  assign last_beat   = beat && (word_idx == LAST_IDX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      word_idx   <= '0;
      last_grant <= GRANT_D;
    end else begin
      state      <= state_nxt;
      word_idx   <= idx_nxt;
      last_grant <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = word_idx;
    grant_nxt = last_grant;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        // On a tie the side that did not win last time is served.
        if (i_req && (!d_req || last_grant == GRANT_D)) begin
          state_nxt = I_XFER;
          grant_nxt = GRANT_I;
        end else if (d_req) begin
          state_nxt = D_XFER;
          grant_nxt = GRANT_D;
        end
      end
      I_XFER, D_XFER: begin
        if (!granted_req) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (beat) begin
          idx_nxt = word_idx + IDX_W'(1);
          if (word_idx == LAST_IDX) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    mem_ren      = 1'b0;
    mem_wen      = 1'b0;
    mem_addr     = '0;
    mem_store    = '0;
    i_load_word  = '0;
    i_load_valid = 1'b0;
    i_done       = 1'b0;
    d_load_word  = '0;
    d_load_valid = 1'b0;
    d_done       = 1'b0;
    case (state)
      I_XFER: begin
        mem_ren      = 1'b1;
        mem_addr     = {i_addr[31:IDX_W+2], word_idx, 2'b00};
        i_load_word  = mem_load;
        i_load_valid = beat;
        i_done       = last_beat;
      end
      D_XFER: begin
        mem_ren      = !d_write;
        mem_wen      = d_write;
        mem_addr     = {d_addr[31:IDX_W+2], word_idx, 2'b00};
        mem_store    = d_store_word;
        d_load_word  = d_write ? '0 : mem_load;
        d_load_valid = beat & !d_write;
        d_done       = last_beat;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fetch_mem_arbiter: scoreboard bench for the icache/dcache memory arbiter.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_mem_arbiter;

  localparam int          BW    = 2;
  localparam int          IW    = 1;
  localparam logic [31:0] KEY   = 32'hC0DE_0000;
  localparam logic [7:0]  TAG_I = 8'h49;
  localparam logic [7:0]  TAG_D = 8'h44;

  logic          CLK = 1'b0;
  logic          RST;
  logic          i_req;
  logic [31:0]   i_addr;
  logic [31:0]   i_load_word;
  logic          i_load_valid;
  logic          i_done;
  logic          d_req;
  logic          d_write;
  logic [31:0]   d_addr;
  logic [31:0]   d_store_word;
  logic [31:0]   d_load_word;
  logic          d_load_valid;
  logic          d_done;
  logic [IW-1:0] word_idx;
  logic          mem_ren;
  logic          mem_wen;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_store;
  logic [31:0]   mem_load;
  logic          mem_ready;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] i_exp[$];
  logic [63:0] d_exp[$];
  logic [63:0] w_exp[$];
  logic [7:0]  done_order[$];
  logic [31:0] store_words[BW];

  fetch_mem_arbiter #(.BLOCK_WORDS(BW)) dut (
    .CLK(CLK), .RST(RST),
    .i_req(i_req), .i_addr(i_addr), .i_load_word(i_load_word),
    .i_load_valid(i_load_valid), .i_done(i_done),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_store_word(d_store_word),
    .d_load_word(d_load_word), .d_load_valid(d_load_valid), .d_done(d_done),
    .word_idx(word_idx), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_store(mem_store), .mem_load(mem_load), .mem_ready(mem_ready)
  );

  always #5 CLK = ~CLK;

  // Memory returns an address-derived word; dcache supplies the word it is asked for.
  assign mem_load     = mem_addr ^ KEY;
  assign d_store_word = store_words[word_idx];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    logic [63:0] e;
    if (!RST) begin
      if (i_load_valid) begin
        if (i_exp.size() == 0) check("i_extra_beat", 64'd1, 64'd0);
        else begin e = i_exp.pop_front(); check("i_beat", {mem_addr, i_load_word}, e); end
      end
      if (d_load_valid) begin
        if (d_exp.size() == 0) check("d_extra_beat", 64'd1, 64'd0);
        else begin e = d_exp.pop_front(); check("d_beat", {mem_addr, d_load_word}, e); end
      end
      if (mem_wen && mem_ready) begin
        if (w_exp.size() == 0) check("w_extra_beat", 64'd1, 64'd0);
        else begin e = w_exp.pop_front(); check("w_beat", {mem_addr, mem_store}, e); end
      end
    end
  end

  task automatic push_i(input logic [31:0] base);
    for (int w = 0; w < BW; w++) i_exp.push_back({base + 32'(4*w), (base + 32'(4*w)) ^ KEY});
  endtask

  task automatic push_d(input logic [31:0] base, input int words);
    for (int w = 0; w < words; w++) d_exp.push_back({base + 32'(4*w), (base + 32'(4*w)) ^ KEY});
  endtask

  // Requesters drop req in the cycle after their done pulse.
  task automatic wait_done(input bit want_i, input bit want_d, input int budget);
    bit got_i, got_d, si, sd;
    got_i = !want_i;
    got_d = !want_d;
    for (int n = 0; n < budget && !(got_i && got_d); n++) begin
      @(negedge CLK);
      si = i_done;
      sd = d_done;
      if (si) begin done_order.push_back(TAG_I); got_i = 1'b1; end
      if (sd) begin done_order.push_back(TAG_D); got_d = 1'b1; end
      @(posedge CLK); #1;
      if (si) i_req = 1'b0;
      if (sd) d_req = 1'b0;
    end
    if (!(got_i && got_d)) begin
      check("done_timeout", {62'd0, got_i, got_d}, {62'd0, 1'b1, 1'b1});
      i_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  task automatic wait_valid(input bit icache, input int budget);
    bit found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge CLK);
      found = icache ? i_load_valid : d_load_valid;
    end
    if (!found) check("valid_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] order_at(input int k);
    return (done_order.size() > k) ? {56'd0, done_order[k]} : 64'd0;
  endfunction

  initial begin
    RST = 1'b1; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; mem_ready = 1'b1;
    store_words[0] = '0; store_words[1] = '0;

    @(negedge CLK);
    check("rst_ren", {63'd0, mem_ren}, 64'd0);
    check("rst_wen", {63'd0, mem_wen}, 64'd0);
    check("rst_idx", {63'd0, word_idx}, 64'd0);
    check("rst_flags", {60'd0, i_load_valid, d_load_valid, i_done, d_done}, 64'd0);
    check("rst_addr", {32'd0, mem_addr}, 64'd0);
    @(posedge CLK); #1 RST = 1'b0;

    // Single icache block: one idle arbitration cycle, then two beats.
    push_i(32'h100); i_addr = 32'h100; i_req = 1'b1;
    @(negedge CLK);
    check("lat_idle_ren", {63'd0, mem_ren}, 64'd0);
    @(negedge CLK);
    check("lat_xfer_ren", {63'd0, mem_ren}, 64'd1);
    wait_done(1'b1, 1'b0, 10);
    @(negedge CLK);
    check("t1_idle_ren", {63'd0, mem_ren}, 64'd0);

    // dcache writeback.
    @(posedge CLK); #1;
    store_words[0] = 32'hAA; store_words[1] = 32'hBB;
    w_exp.push_back({32'h208, 32'hAA}); w_exp.push_back({32'h20C, 32'hBB});
    d_write = 1'b1; d_addr = 32'h208; d_req = 1'b1;
    wait_done(1'b0, 1'b1, 10);
    d_write = 1'b0;

    // Simultaneous requests twice: icache leads both times.
    for (int r = 0; r < 2; r++) begin
      done_order.delete();
      i_addr = 32'h600 + 32'(r * 'h40); d_addr = 32'h500 + 32'(r * 'h40);
      push_i(i_addr); push_d(d_addr, BW);
      i_req = 1'b1; d_req = 1'b1;
      wait_done(1'b1, 1'b1, 30);
      check($sformatf("tie%0d_first", r), order_at(0), {56'd0, TAG_I});
      check($sformatf("tie%0d_second", r), order_at(1), {56'd0, TAG_D});
    end

    // Stall three cycles after the first beat.
    push_i(32'h300); i_addr = 32'h300; i_req = 1'b1;
    wait_valid(1'b1, 10);
    @(posedge CLK); #1 mem_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      check("stall_idx", {63'd0, word_idx}, 64'd1);
      check("stall_addr", {32'd0, mem_addr}, 64'h304);
      check("stall_en", {62'd0, mem_ren, mem_wen}, 64'd2);
      check("stall_valid", {62'd0, i_load_valid, i_done}, 64'd0);
    end
    @(posedge CLK); #1 mem_ready = 1'b1;
    wait_done(1'b1, 1'b0, 10);

    // dcache wins the tie (icache went last), then aborts after word 0.
    push_d(32'h400, 1); d_addr = 32'h400; d_write = 1'b0;
    push_i(32'h900); i_addr = 32'h900;
    i_req = 1'b1; d_req = 1'b1;
    wait_valid(1'b0, 10);
    @(posedge CLK); #1 d_req = 1'b0;
    @(negedge CLK);
    check("ab_no_beat", {62'd0, d_load_valid, d_done}, 64'd0);
    @(negedge CLK);
    check("ab_idle_en", {62'd0, mem_ren, mem_wen}, 64'd0);
    check("ab_idle_idx", {63'd0, word_idx}, 64'd0);
    check("ab_no_done", {63'd0, d_done}, 64'd0);
    done_order.delete();
    wait_done(1'b1, 1'b0, 10);
    check("ab_i_next", order_at(0), {56'd0, TAG_I});

    // Reset during icache word 1.
    push_i(32'h700); i_addr = 32'h700; i_req = 1'b1;
    wait_valid(1'b1, 10);
    @(posedge CLK); #1 RST = 1'b1;
    #1;
    check("rm_en", {62'd0, mem_ren, mem_wen}, 64'd0);
    check("rm_idx", {63'd0, word_idx}, 64'd0);
    check("rm_valid", {63'd0, i_load_valid}, 64'd0);
    i_exp.delete();
    i_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    done_order.delete();
    push_i(32'h700); push_d(32'h800, BW); d_addr = 32'h800;
    i_req = 1'b1; d_req = 1'b1;
    wait_done(1'b1, 1'b1, 30);
    check("rm_first", order_at(0), {56'd0, TAG_I});
    check("rm_second", order_at(1), {56'd0, TAG_D});

    @(negedge CLK);
    check("i_q_left", 64'(i_exp.size()), 64'd0);
    check("d_q_left", 64'(d_exp.size()), 64'd0);
    check("w_q_left", 64'(w_exp.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
